lh_digest_hex_tx: RTL and testbench
===================================

# lh_digest_hex_tx

Downstream stage of the light-hash core. It captures each 64-bit digest when the core raises `digest_ready` and serialises it as 16 ASCII hex characters, most-significant nibble first, plus an optional terminator byte. Output is a byte stream with a valid/ready handshake toward the UART/host-side consumer. Digests that arrive while a frame is still being sent are dropped and flagged as overrun.

## Interface
Parameters:
- `UPPERCASE`, default 0: 0 selects hex letters `a`–`f` (0x61–0x66); 1 selects `A`–`F` (0x41–0x46).
- `TERM_EN`, default 1: 1 appends the terminator byte after the 16th character.
- `TERM_CHAR`, default 8'h0A: value of the terminator byte.

Ports:
- `clk` in 1: the single clock. All logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `digest_char` in 64: digest from the hash core. Valid while `digest_ready` is high.
- `digest_ready` in 1: level from the hash core. A new digest is signalled by its rising edge.
- `out_char` out 8: ASCII byte being offered.
- `out_valid` out 1: `out_char` is valid.
- `out_ready` in 1: consumer accepts a byte. A transfer happens when `out_valid && out_ready`.
- `busy` out 1: a frame is in progress.
- `overrun` out 1: sticky flag, set when a digest was dropped.
- `overrun_clr` in 1: synchronous clear for `overrun`.

## Operation
- **Edge detect.** `rdy_q` is a register holding `digest_ready` from the previous cycle. `new_dig = digest_ready & ~rdy_q`.
- **State machine** (IDLE, SEND, TERM):
  - IDLE: on `new_dig`, latch `digest_char` into the 64-bit `shreg`, set `nib_idx` to 0, go to SEND.
  - SEND: `out_valid` = 1, `out_char` = ascii(`shreg[63-4*nib_idx -: 4]`). On a transfer, `nib_idx` increments. On the transfer with `nib_idx` = 15, go to TERM if `TERM_EN`, otherwise to IDLE.
  - TERM: `out_valid` = 1, `out_char` = `TERM_CHAR`. On a transfer, go to IDLE.
- **Hex mapping.** Nibble n from 0 to 9 maps to 0x30+n. Nibble n from 10 to 15 maps to 0x61+(n-10), or 0x41+(n-10) when `UPPERCASE` = 1.
- **Output stability.** While `out_valid` is high and `out_ready` is low, `out_char` must not change.
- **`busy`.** High exactly when the state is not IDLE.
- **Overrun.**
  - Definition of the last transfer: the final transfer of the frame, i.e. the `nib_idx` = 15 transfer in SEND when `TERM_EN` = 0, or the TERM transfer when `TERM_EN` = 1.
  - `new_dig` while `busy`, in any cycle other than the last transfer: `overrun` is set and the digest is discarded.
  - `new_dig` in the same cycle as the last transfer: the digest is captured and the next frame starts.
  - If `overrun_clr` and an overrun set occur in the same cycle, the set wins.
- **Reset mid-frame.** The frame is aborted and nothing further is emitted. After release, the block waits for a fresh rising edge of `digest_ready`. If `digest_ready` is already high at release, `rdy_q` resets to 0, so that level counts as an edge one cycle after release.

## Timing
- **Reset values:** `out_char` = 8'h00, `out_valid` = 0, `busy` = 0, `overrun` = 0, `rdy_q` = 0, state IDLE, `nib_idx` = 0, `shreg` = 0.
- **Latency:** `new_dig` sampled at edge N gives `out_valid` = 1 with the first character from edge N onward, i.e. in cycle N+1. All outputs are registered.
- **Throughput:** with `out_ready` held at 1, one byte per cycle. A frame takes 17 cycles with `TERM_EN` = 1 and 16 cycles with `TERM_EN` = 0.
- **Back-to-back frames:** no idle cycle is required between the last transfer of one frame and the first byte of the next.
- **Overrun:** `overrun` rises on the edge after the dropped `new_dig`.

## Structure
- **Package `lh_pkg`:**
  - state enum `lh_tx_state_t` (IDLE, SEND, TERM)
  - `NULL_CHAR` = 8'h00
  - ASCII constants `ASCII_0` = 8'h30, `ASCII_LA` = 8'h61, `ASCII_UA` = 8'h41
  - default terminator `LH_TERM_LF` = 8'h0A
- **Sub-module `lh_nibble2ascii`:** combinational, 4-bit in, 8-bit out, with parameter `UPPERCASE`. It is reusable by other debug printers.
- **Top-level contents:** FSM, shift/index registers, overrun logic.

## Test plan
- **Single frame, lowercase:** after reset, set `digest_char` = 64'h0123456789ABCDEF, pulse `digest_ready` high, hold `out_ready` = 1. Required: bytes 30 31 … 39 61 62 63 64 65 66 0A, one per cycle starting one cycle after the edge; `busy` deasserts after the 0A transfer.
- **Backpressure:** digest 64'hFFFF_0000_A5A5_5A5A, `UPPERCASE` = 1, `out_ready` toggling randomly. Required: the stream is "FFFF0000A5A55A5A" then 0A, and `out_char` stays stable whenever `out_valid && !out_ready`.
- **Overrun:** start a frame, then give a second `digest_ready` edge in the 5th SEND cycle. Required: `overrun` = 1 on the next edge and the first frame completes unchanged. Then assert `overrun_clr` together with another mid-frame edge. Required: `overrun` stays 1.
- **Back-to-back:** a second edge coincides with the TERM transfer. Required: the second frame's first byte appears in the next cycle and `overrun` stays 0.
- **Reset mid-frame and level-high restart:** assert `rst_n` = 0 after 7 bytes, with `digest_ready` left high. Required: all outputs take their reset values immediately. After release, a new frame starts from nibble 0 of the current `digest_char`, offered one cycle after the edge detected on the first post-reset clock.
- **`TERM_EN` = 0:** digest 64'h0. Required: exactly 16 bytes of 0x30, then `busy` = 0.

Source files
------------

// File: rtl/lh_pkg.sv
// Shared types and constants for the light-hash digest printers.
// Holds the transmitter state encoding and the ASCII code points used for hex output.
package lh_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        TERM = 2'd2
    } lh_tx_state_t;

    localparam logic [7:0] NULL_CHAR  = 8'h00;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_LA   = 8'h61;
    localparam logic [7:0] ASCII_UA   = 8'h41;
    localparam logic [7:0] LH_TERM_LF = 8'h0A;

    localparam logic [3:0] NIB_LAST   = 4'd15;

    // Code point of 'a' or 'A', depending on the requested letter case.
    function automatic logic [7:0] hex_letter_base(input logic upper);
        return upper ? ASCII_UA : ASCII_LA;
    endfunction

endpackage

// File: rtl/lh_nibble2ascii.sv
// Combinational 4-bit to ASCII hex digit converter.
// Letter case is fixed at elaboration time through UPPERCASE.
module lh_nibble2ascii
    import lh_pkg::*;
#(
    parameter bit UPPERCASE = 1'b0
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    logic [7:0] nib_ext;

    always_comb begin
        nib_ext = {4'd0, nibble};
        if (nibble < 4'd10) begin
            ascii = ASCII_0 + nib_ext;
        end else begin
            ascii = hex_letter_base(UPPERCASE) + (nib_ext - 8'd10);
        end
    end

endmodule

// File: rtl/lh_digest_hex_tx.sv
// Serialises each 64-bit hash digest as 16 ASCII hex characters (MS nibble first)
// plus an optional terminator, over a valid/ready byte stream with overrun detection.
module lh_digest_hex_tx
    import lh_pkg::*;
#(
    parameter bit         UPPERCASE = 1'b0,
    parameter bit         TERM_EN   = 1'b1,
    parameter logic [7:0] TERM_CHAR = LH_TERM_LF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] digest_char,
    input  logic        digest_ready,
    output logic [7:0]  out_char,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        overrun,
    input  logic        overrun_clr
);

    lh_tx_state_t state_q, state_d;
    logic [63:0]  shreg_q, shreg_d;
    logic [3:0]   nib_idx_q, nib_idx_d;
    logic         rdy_q, rdy_d;
    logic         overrun_q, overrun_d;
    logic [7:0]   out_char_q, out_char_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;

    logic         new_dig;
    logic         xfer;
    logic         last_xfer;
    logic [5:0]   nib_msb;
    logic [3:0]   nib_sel;
    logic [7:0]   nib_ascii;

    assign new_dig = digest_ready & ~rdy_q;
    assign xfer    = out_valid_q & out_ready;
    assign rdy_d   = digest_ready;

    // The frame's final byte is the terminator when enabled, otherwise nibble 15.
    always_comb begin
        last_xfer = 1'b0;
        if (xfer) begin
            if (TERM_EN) begin
                last_xfer = (state_q == TERM);
            end else begin
                last_xfer = (state_q == SEND) && (nib_idx_q == NIB_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= 64'd0;
            nib_idx_q   <= 4'd0;
            rdy_q       <= 1'b0;
            overrun_q   <= 1'b0;
            out_char_q  <= NULL_CHAR;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            nib_idx_q   <= nib_idx_d;
            rdy_q       <= rdy_d;
            overrun_q   <= overrun_d;
            out_char_q  <= out_char_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        nib_idx_d = nib_idx_q;
        overrun_d = overrun_q & ~overrun_clr;

        case (state_q)
            IDLE: begin
                if (new_dig) begin
                    state_d   = SEND;
                    shreg_d   = digest_char;
                    nib_idx_d = 4'd0;
                end
            end
            SEND: begin
                if (xfer) begin
                    nib_idx_d = nib_idx_q + 4'd1;
                    if (nib_idx_q == NIB_LAST) begin
                        state_d = TERM_EN ? TERM : IDLE;
                    end
                end
            end
            TERM: begin
                if (xfer) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A digest landing on the final transfer chains straight into the next frame;
        // anywhere else mid-frame it is dropped. Setting overrides the clear.
        if (new_dig && (state_q != IDLE)) begin
            if (last_xfer) begin
                state_d   = SEND;
                shreg_d   = digest_char;
                nib_idx_d = 4'd0;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Output registers are loaded from the next state so the first character
    // appears in the cycle right after the digest edge is sampled.
    always_comb begin
        nib_msb = 6'd63 - {nib_idx_d, 2'b00};
        nib_sel = shreg_d[nib_msb -: 4];
    end

    lh_nibble2ascii #(
        .UPPERCASE(UPPERCASE)
    ) u_nib2ascii (
        .nibble(nib_sel),
        .ascii (nib_ascii)
    );

    always_comb begin
        out_valid_d = (state_d != IDLE);
        busy_d      = (state_d != IDLE);
        case (state_d)
            SEND:    out_char_d = nib_ascii;
            TERM:    out_char_d = TERM_CHAR;
            default: out_char_d = NULL_CHAR;
        endcase
    end

    assign out_char  = out_char_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_lh_digest_hex_tx.sv
// Directed bench for lh_digest_hex_tx: default, uppercase and no-terminator builds
// driven side by side from one linear stimulus sequence.
module tb_lh_digest_hex_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic [63:0] dig_a, dig_u, dig_n;
    logic        rdy_a, rdy_u, rdy_n;
    logic        ordy_a, ordy_u, ordy_n;
    logic        clr_a, clr_u, clr_n;
    logic [7:0]  char_a, char_u, char_n;
    logic        val_a, val_u, val_n;
    logic        busy_a, busy_u, busy_n;
    logic        ovr_a, ovr_u, ovr_n;

    int errors = 0;
    int checks = 0;

    lh_digest_hex_tx dut_a (
        .clk(clk), .rst_n(rst_n), .digest_char(dig_a), .digest_ready(rdy_a),
        .out_char(char_a), .out_valid(val_a), .out_ready(ordy_a), .busy(busy_a),
        .overrun(ovr_a), .overrun_clr(clr_a)
    );

    lh_digest_hex_tx #(.UPPERCASE(1'b1)) dut_u (
        .clk(clk), .rst_n(rst_n), .digest_char(dig_u), .digest_ready(rdy_u),
        .out_char(char_u), .out_valid(val_u), .out_ready(ordy_u), .busy(busy_u),
        .overrun(ovr_u), .overrun_clr(clr_u)
    );

    lh_digest_hex_tx #(.TERM_EN(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .digest_char(dig_n), .digest_ready(rdy_n),
        .out_char(char_n), .out_valid(val_n), .out_ready(ordy_n), .busy(busy_n),
        .overrun(ovr_n), .overrun_clr(clr_n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        string exp_s;
        int    k;

        rst_n = 1'b0;
        dig_a = 64'd0; dig_u = 64'd0; dig_n = 64'd0;
        rdy_a = 1'b0;  rdy_u = 1'b0;  rdy_n = 1'b0;
        ordy_a = 1'b1; ordy_u = 1'b0; ordy_n = 1'b1;
        clr_a = 1'b0;  clr_u = 1'b0;  clr_n = 1'b0;

        // Reset values
        #2;
        check("rst_char", char_a, 8'h00);
        check("rst_valid", val_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_ovr", ovr_a, 1'b0);
        repeat (2) tick();
        check("rst_valid_u", val_u, 1'b0);
        check("rst_valid_n", val_n, 1'b0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy_a, 1'b0);

        // No terminator: 16 x '0' then idle
        dig_n = 64'h0;
        rdy_n = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            check("nt_valid", val_n, 1'b1);
            check("nt_char", char_n, 8'h30);
            if (i == 0) rdy_n = 1'b0;
            tick();
        end
        check("nt_busy_end", busy_n, 1'b0);
        check("nt_valid_end", val_n, 1'b0);

        // Uppercase with random backpressure
        dig_u = 64'hFFFF_0000_A5A5_5A5A;
        exp_s = "FFFF0000A5A55A5A";
        rdy_u = 1'b1;
        tick();
        rdy_u = 1'b0;
        k = 0;
        for (int cyc = 0; cyc < 300 && k < 17; cyc++) begin
            ordy_u = 1'($urandom_range(0, 1));
            check("bp_valid", val_u, 1'b1);
            check("bp_char", char_u, (k < 16) ? exp_s[k] : 8'h0A);
            if (val_u && ordy_u) k++;
            tick();
        end
        check("bp_count", k, 17);
        check("bp_busy_end", busy_u, 1'b0);
        ordy_u = 1'b0;

        // Single frame, lowercase
        dig_a = 64'h0123_4567_89AB_CDEF;
        exp_s = "0123456789abcdef";
        rdy_a = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            check("f1_valid", val_a, 1'b1);
            check("f1_char", char_a, exp_s[i]);
            if (i == 0) rdy_a = 1'b0;
            tick();
        end
        check("f1_term", char_a, 8'h0A);
        check("f1_busy_term", busy_a, 1'b1);
        tick();
        check("f1_busy_end", busy_a, 1'b0);
        check("f1_valid_end", val_a, 1'b0);

        // Overrun: edge in the 5th SEND cycle
        dig_a = 64'hFEDC_BA98_7654_3210;
        exp_s = "fedcba9876543210";
        rdy_a = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            check("ov_char", char_a, exp_s[i]);
            if (i == 0) rdy_a = 1'b0;
            if (i == 4) begin
                check("ov_pre", ovr_a, 1'b0);
                rdy_a = 1'b1;
                dig_a = 64'h1111_1111_1111_1111;
            end
            if (i == 5) begin
                check("ov_set", ovr_a, 1'b1);
                rdy_a = 1'b0;
            end
            tick();
        end
        check("ov_term", char_a, 8'h0A);
        tick();
        check("ov_busy_end", busy_a, 1'b0);
        check("ov_sticky", ovr_a, 1'b1);

        // Clear together with another drop: set wins
        dig_a = 64'h0;
        rdy_a = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            check("ovc_char", char_a, 8'h30);
            if (i == 0) rdy_a = 1'b0;
            if (i == 3) begin
                rdy_a = 1'b1;
                clr_a = 1'b1;
            end
            if (i == 4) begin
                check("ovc_set_wins", ovr_a, 1'b1);
                rdy_a = 1'b0;
                clr_a = 1'b0;
            end
            tick();
        end
        check("ovc_term", char_a, 8'h0A);
        tick();
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("ovc_cleared", ovr_a, 1'b0);

        // Back-to-back: next edge on the terminator transfer
        dig_a = 64'hDEAD_BEEF_CAFE_F00D;
        exp_s = "deadbeefcafef00d";
        rdy_a = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            check("bb_char", char_a, exp_s[i]);
            if (i == 0) rdy_a = 1'b0;
            tick();
        end
        check("bb_term", char_a, 8'h0A);
        rdy_a = 1'b1;
        dig_a = 64'h1234_5678_9ABC_DEF0;
        tick();
        check("bb_next_valid", val_a, 1'b1);
        check("bb_next_char", char_a, 8'h31);
        check("bb_next_busy", busy_a, 1'b1);
        check("bb_no_ovr", ovr_a, 1'b0);

        // Reset after 7 bytes with digest_ready held high
        exp_s = "123456789abcdef0";
        for (int i = 0; i < 7; i++) begin
            check("rm_char", char_a, exp_s[i]);
            tick();
        end
        check("rm_before", char_a, 8'h38);
        rst_n = 1'b0;
        #1;
        check("rm_char_rst", char_a, 8'h00);
        check("rm_valid_rst", val_a, 1'b0);
        check("rm_busy_rst", busy_a, 1'b0);
        check("rm_ovr_rst", ovr_a, 1'b0);
        dig_a = 64'h89AB_CDEF_0123_4567;
        repeat (2) tick();
        rst_n = 1'b1;
        check("rm_hold_valid", val_a, 1'b0);
        tick();
        check("rm_restart_valid", val_a, 1'b1);
        exp_s = "89abcdef01234567";
        for (int i = 0; i < 16; i++) begin
            check("rm_frame_char", char_a, exp_s[i]);
            tick();
        end
        check("rm_term", char_a, 8'h0A);
        tick();
        check("rm_busy_end", busy_a, 1'b0);
        tick();
        check("rm_level_no_edge", val_a, 1'b0);
        rdy_a = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
